ultrasonic_ranger: RTL and testbench



---
 rtl/ultrasonic_ranger.sv | 203 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - alternating X/Y HC-SR04 ping, echo width measurement, clamped grid coordinate
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES     = 1000,
    parameter int CYCLES_PER_UNIT = 11600,
    parameter int TIMEOUT_CYCLES  = 3000000,
    parameter int SETTLE_CYCLES   = 6000000,
    parameter int MIN_COORD       = 0,
    parameter int MAX_COORD       = 15,
    parameter int DEFAULT_COORD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       echo_x,
    input  logic       echo_y,
    output logic       trig_x,
    output logic       trig_y,
    output logic [7:0] ultrasonic_x,
    output logic [7:0] ultrasonic_y,
    output logic       sample_valid,
    output logic       timeout_x,
    output logic       timeout_y
);

    localparam int GW = $clog2(TRIG_CYCLES + 1);
    localparam int PW = $clog2(CYCLES_PER_UNIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [GW-1:0] TRIG_LIM    = GW'(TRIG_CYCLES);
    localparam logic [PW-1:0] SUB_LAST    = PW'(CYCLES_PER_UNIT - 1);
    localparam logic [PW-1:0] SUB_FIRST   = (CYCLES_PER_UNIT == 1) ? '0 : PW'(1);
    localparam logic [7:0]    UNITS_FIRST = (CYCLES_PER_UNIT == 1) ? 8'd1 : 8'd0;
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [8:0]    MIN9        = 9'(MIN_COORD);
    localparam logic [8:0]    MAX9        = 9'(MAX_COORD);
    localparam logic [7:0]    DEF8        = 8'(DEFAULT_COORD);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        SETTLE
    } state_t;

    state_t        state;
    logic          sel;
    logic [GW-1:0] trig_cnt;
    logic [PW-1:0] sub_cnt;
    logic [7:0]    units;
    logic [TW-1:0] timeout_cnt;
    logic [SW-1:0] settle_cnt;

    // [0],[1] synchronize the pin; [2] is the previous synchronized value for edge detection
    logic [2:0] x_sync;
    logic [2:0] y_sync;

    logic       echo_now;
    logic       echo_prev;
    logic       echo_rise;
    logic       echo_fall;
    logic [8:0] coord_sum;
    logic [7:0] coord;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_sync <= '0;
            y_sync <= '0;
        end else begin
            x_sync <= {x_sync[1:0], echo_x};
            y_sync <= {y_sync[1:0], echo_y};
        end
    end

    always_comb begin
        echo_now  = sel ? y_sync[1] : x_sync[1];
        echo_prev = sel ? y_sync[2] : x_sync[2];
        echo_rise = echo_now & ~echo_prev;
        echo_fall = ~echo_now & echo_prev;
    end

    always_comb begin
        coord_sum = {1'b0, units} + MIN9;
        if (coord_sum <= MIN9) begin
            coord = MIN9[7:0];
        end else if (coord_sum >= MAX9) begin
            coord = MAX9[7:0];
        end else begin
            coord = coord_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= 1'b0;
            trig_cnt     <= '0;
            sub_cnt      <= '0;
            units        <= '0;
            timeout_cnt  <= '0;
            settle_cnt   <= '0;
            trig_x       <= 1'b0;
            trig_y       <= 1'b0;
            ultrasonic_x <= DEF8;
            ultrasonic_y <= DEF8;
            sample_valid <= 1'b0;
            timeout_x    <= 1'b0;
            timeout_y    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state != IDLE && !enable) begin
                // abandon the ping; sel is kept so the same sensor is pinged again
                state       <= IDLE;
                trig_x      <= 1'b0;
                trig_y      <= 1'b0;
                trig_cnt    <= '0;
                sub_cnt     <= '0;
                units       <= '0;
                timeout_cnt <= '0;
                settle_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        trig_x <= 1'b0;
                        trig_y <= 1'b0;
                        if (enable) begin
                            state    <= TRIG;
                            trig_cnt <= '0;
                        end
                    end
                    TRIG: begin
                        if (trig_cnt == TRIG_LIM) begin
                            trig_x      <= 1'b0;
                            trig_y      <= 1'b0;
                            timeout_cnt <= '0;
                            state       <= WAIT_RISE;
                        end else begin
                            trig_x   <= ~sel;
                            trig_y   <= sel;
                            trig_cnt <= trig_cnt + 1'b1;
                        end
                    end
                    WAIT_RISE: begin
                        if (timeout_cnt == TIMEOUT_LIM) begin
                            if (sel) timeout_y <= 1'b1;
                            else     timeout_x <= 1'b1;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                            if (echo_rise) begin
                                // the rising cycle is already an echo-high cycle
                                sub_cnt <= SUB_FIRST;
                                units   <= UNITS_FIRST;
                                state   <= MEASURE;
                            end
                        end
                    end
                    MEASURE: begin
                        if (echo_fall) begin
                            if (sel) begin
                                ultrasonic_y <= coord;
                                timeout_y    <= 1'b0;
                            end else begin
                                ultrasonic_x <= coord;
                                timeout_x    <= 1'b0;
                            end
                            sample_valid <= 1'b1;
                            settle_cnt   <= '0;
                            state        <= SETTLE;
                        end else if (timeout_cnt == TIMEOUT_LIM) begin
                            if (sel) timeout_y <= 1'b1;
                            else     timeout_x <= 1'b1;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                            if (sub_cnt == SUB_LAST) begin
                                sub_cnt <= '0;
                                if (units != 8'hFF) units <= units + 1'b1;
                            end else begin
                                sub_cnt <= sub_cnt + 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            sel      <= ~sel;
                            trig_cnt <= '0;
                            state    <= TRIG;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - directed and randomized ping sequence checked against a width-to-coordinate model
module tb_ultrasonic_ranger;

    localparam int TRIG    = 4;
    localparam int CPU     = 10;
    localparam int TIMEOUT = 500;
    localparam int SETTLE  = 20;
    localparam int MINC    = 0;
    localparam int MAXC    = 15;
    localparam int DEFC    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       echo_x = 1'b0;
    logic       echo_y = 1'b0;
    logic       trig_x;
    logic       trig_y;
    logic [7:0] ultrasonic_x;
    logic [7:0] ultrasonic_y;
    logic       sample_valid;
    logic       timeout_x;
    logic       timeout_y;

    int total = 0;
    int bad = 0;
    int exp_x = DEFC;
    int exp_y = DEFC;
    int exp_tx = 0;
    int exp_ty = 0;

    ultrasonic_ranger #(
        .TRIG_CYCLES    (TRIG),
        .CYCLES_PER_UNIT(CPU),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SETTLE_CYCLES  (SETTLE),
        .MIN_COORD      (MINC),
        .MAX_COORD      (MAXC),
        .DEFAULT_COORD  (DEFC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .echo_x      (echo_x),
        .echo_y      (echo_y),
        .trig_x      (trig_x),
        .trig_y      (trig_y),
        .ultrasonic_x(ultrasonic_x),
        .ultrasonic_y(ultrasonic_y),
        .sample_valid(sample_valid),
        .timeout_x   (timeout_x),
        .timeout_y   (timeout_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_x"}, 32'(ultrasonic_x), exp_x);
        check({tag, "_y"}, 32'(ultrasonic_y), exp_y);
        check({tag, "_tx"}, 32'(timeout_x), exp_tx);
        check({tag, "_ty"}, 32'(timeout_y), exp_ty);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_trig_x"}, 32'(trig_x), 0);
        check({tag, "_trig_y"}, 32'(trig_y), 0);
        check({tag, "_valid"}, 32'(sample_valid), 0);
        check_outputs(tag);
    endtask

    // waits for the next trigger, checks sensor and width; returns one sample after it falls
    task automatic wait_trig(input bit axis, input string tag, output int gap);
        int  n;
        int  width;
        bit  seen;
        bit  other;
        seen = 1'b0;
        gap  = -1;
        for (n = 1; n <= 200; n++) begin
            tick();
            if (trig_x || trig_y) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_trig_seen"}, 32'(seen), 1);
        if (!seen) return;
        gap = n;
        check({tag, "_trig_axis"}, 32'(trig_y), 32'(axis));
        width = 0;
        other = 1'b0;
        while ((axis ? trig_y : trig_x) && width < 50) begin
            width++;
            if (axis ? trig_x : trig_y) other = 1'b1;
            tick();
        end
        check({tag, "_trig_width"}, width, TRIG);
        check({tag, "_other_trig"}, 32'(other), 0);
    endtask

    task automatic echo_pulse(input bit axis, input int delay, input int width);
        repeat (delay) tick();
        if (axis) echo_y = 1'b1;
        else      echo_x = 1'b1;
        repeat (width) tick();
        echo_x = 1'b0;
        echo_y = 1'b0;
    endtask

    task automatic wait_sample(input string tag);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (sample_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_valid_seen"}, 32'(got), 1);
        tick();
        check({tag, "_valid_single"}, 32'(sample_valid), 0);
    endtask

    // reference: whole grid units of echo-high time, offset and clamped
    task automatic ping(input bit axis, input int delay, input int width, input string tag);
        int e;
        echo_pulse(axis, delay, width);
        wait_sample(tag);
        e = width / CPU + MINC;
        if (e > MAXC) e = MAXC;
        if (e < MINC) e = MINC;
        if (axis) begin
            exp_y  = e;
            exp_ty = 0;
        end else begin
            exp_x  = e;
            exp_tx = 0;
        end
        check_outputs(tag);
    endtask

    initial begin
        int  gap;
        int  n;
        bit  seen;
        bit  stray;
        bit  axis;

        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b0;

        wait_trig(1'b0, "first", gap);
        check("first_trig_start", gap, 2);
        check_outputs("first_hold");

        ping(1'b0, 5, 73, "x73");
        wait_trig(1'b1, "y_after_x73", gap);
        check_range("settle_gap", gap, 19, 22);

        ping(1'b1, 5, 400, "y400");

        wait_trig(1'b0, "x_noecho", gap);
        seen  = 1'b0;
        stray = 1'b0;
        for (n = 1; n <= 700; n++) begin
            tick();
            if (sample_valid) stray = 1'b1;
            if (timeout_x) begin
                seen = 1'b1;
                break;
            end
        end
        check("timeout_seen", 32'(seen), 1);
        check_range("timeout_delay", n, TIMEOUT - 1, TIMEOUT + 3);
        check("timeout_no_valid", 32'(stray), 0);
        exp_tx = 1;
        check_outputs("timeout");

        wait_trig(1'b1, "y_after_timeout", gap);
        ping(1'b1, $urandom_range(2, 30), $urandom_range(20, 160), "y_after_timeout");

        echo_x = 1'b1;
        wait_trig(1'b0, "x_prehigh", gap);
        repeat (10) tick();
        echo_x = 1'b0;
        ping(1'b0, 6, 35, "x_prehigh");

        wait_trig(1'b1, "y_rand", gap);
        ping(1'b1, $urandom_range(2, 30), $urandom_range(1, 220), "y_rand");

        wait_trig(1'b0, "x_drop", gap);
        repeat (3) tick();
        echo_x = 1'b1;
        repeat (15) tick();
        enable = 1'b0;
        tick();
        stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (trig_x || trig_y || sample_valid) stray = 1'b1;
        end
        echo_x = 1'b0;
        check("drop_quiet", 32'(stray), 0);
        check_outputs("drop");
        repeat (5) tick();
        enable = 1'b1;
        wait_trig(1'b0, "x_reping", gap);
        ping(1'b0, $urandom_range(2, 30), $urandom_range(1, 220), "x_reping");

        axis = 1'b1;
        for (int r = 0; r < 6; r++) begin
            wait_trig(axis, $sformatf("rand%0d", r), gap);
            ping(axis, $urandom_range(2, 40), $urandom_range(1, 220), $sformatf("rand%0d", r));
            axis = ~axis;
        end

        wait_trig(axis, "mid_reset", gap);
        if (axis) echo_y = 1'b1;
        else      echo_x = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        exp_x  = DEFC;
        exp_y  = DEFC;
        exp_tx = 0;
        exp_ty = 0;
        check_reset_state("mid_reset");
        echo_x = 1'b0;
        echo_y = 1'b0;
        reset  = 1'b0;
        wait_trig(1'b0, "after_reset", gap);
        check("after_reset_start", gap, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
